// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad bus arbiter.
// Pure declarations; no logic, no latency.
// Backpressure: not applicable.
package uio_arb_pkg;
    localparam int BUS_W = 8;
    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;
    localparam logic [BUS_W-1:0] OE_ON = 8'hFF;

    typedef enum logic [1:0] {IDLE, TURN, XFER} state_t;

    // Pad enable pattern for a bus parked in the given direction.
    function automatic logic [BUS_W-1:0] oe_for(input logic dir);
        return (dir == DIR_WR) ? OE_ON : '0;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PW-1:0]    idx,
    output logic             any
);
    int            pos;
    logic [PW-1:0] pos_idx;

    always_comb begin
        onehot  = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            pos_idx = PW'(pos);
            if (!any && req[pos_idx]) begin
                any             = 1'b1;
                idx             = pos_idx;
                onehot[pos_idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the bidirectional uio pads among N_REQ requesters in bursts.
// Latency: grant 1 cycle after request (plus TURN_CYC on a direction change); rdata 1 cycle after beat.
// Backpressure: requester holds req for the burst; dropping req or MAX_BURST beats ends the grant.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    parameter int TURN_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   wr,
    input  logic [8*N_REQ-1:0] wdata,
    output logic [N_REQ-1:0]   grant,
    output logic [BUS_W-1:0]   rdata,
    output logic               rvalid,
    output logic               busy,
    input  logic [BUS_W-1:0]   uio_in,
    output logic [BUS_W-1:0]   uio_out,
    output logic [BUS_W-1:0]   uio_oe
);
    localparam int PW = $clog2(N_REQ);

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    w;
    logic [N_REQ-1:0] w_oh;
    logic             dir;
    logic             last_dir;
    logic [3:0]       beat_cnt;
    logic [1:0]       turn_cnt;

    logic [N_REQ-1:0] pick_onehot;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;
    logic             beat;
    logic             last_beat;
    logic [PW-1:0]    ptr_next;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign beat      = grant[w] && req[w];
    assign last_beat = (beat_cnt >= 4'(MAX_BURST - 1));
    assign ptr_next  = (w == PW'(N_REQ - 1)) ? '0 : w + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            w        <= '0;
            w_oh     <= '0;
            dir      <= DIR_RD;
            last_dir <= DIR_RD;
            beat_cnt <= '0;
            turn_cnt <= '0;
            grant    <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            busy     <= 1'b0;
            uio_out  <= '0;
            uio_oe   <= '0;
        end else if (!ena) begin
            // Abort: pads released and direction forgotten so the next write pays a turnaround.
            state    <= IDLE;
            grant    <= '0;
            rvalid   <= 1'b0;
            busy     <= 1'b0;
            uio_oe   <= '0;
            last_dir <= DIR_RD;
        end else begin
            rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        w        <= pick_idx;
                        w_oh     <= pick_onehot;
                        dir      <= wr[pick_idx];
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                        if (wr[pick_idx] != last_dir) begin
                            state    <= TURN;
                            turn_cnt <= '0;
                            uio_oe   <= '0;
                        end else begin
                            state <= XFER;
                            grant <= pick_onehot;
                        end
                    end
                end
                TURN: begin
                    if (turn_cnt == 2'(TURN_CYC - 1)) begin
                        state    <= XFER;
                        grant    <= w_oh;
                        last_dir <= dir;
                        uio_oe   <= oe_for(dir);
                        beat_cnt <= '0;
                    end else begin
                        turn_cnt <= turn_cnt + 2'd1;
                    end
                end
                XFER: begin
                    if (beat) begin
                        if (dir == DIR_WR) begin
                            uio_out <= wdata[BUS_W*int'(w) +: BUS_W];
                            uio_oe  <= OE_ON;
                        end else begin
                            rdata  <= uio_in;
                            rvalid <= 1'b1;
                        end
                        if (beat_cnt != 4'hF) beat_cnt <= beat_cnt + 4'd1;
                    end
                    if (!beat || last_beat) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= ptr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: reset, write/read bursts, turnarounds,
// round-robin order, ena abort and async reset.
module tb_uio_bus_arbiter;
    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [31:0] wdata;
    logic [3:0]  grant;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        busy;
    logic [7:0]  uio_in;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [3:0] oh;

    uio_bus_arbiter #(.N_REQ(4), .MAX_BURST(4), .TURN_CYC(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req     (req),
        .wr      (wr),
        .wdata   (wdata),
        .grant   (grant),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .busy    (busy),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; req = '0; wr = '0; wdata = '0; uio_in = '0;
        #3;
        chk("rst_grant",  32'(grant),   32'h0);
        chk("rst_rdata",  32'(rdata),   32'h0);
        chk("rst_rvalid", 32'(rvalid),  32'h0);
        chk("rst_busy",   32'(busy),    32'h0);
        chk("rst_out",    32'(uio_out), 32'h0);
        chk("rst_oe",     32'(uio_oe),  32'h0);
        #9 rst_n = 1'b1;
        ena = 1'b1;

        // Idle bus with no requests
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle", 32'({grant, uio_oe, busy}), 32'h0);
        end

        // Write burst from requester 1, capped at 4 beats, with one turnaround
        req = 4'b0010; wr = 4'b0010; wdata = 32'h0000_A500;
        tick(); chk("t2_turn_oe", 32'(uio_oe), 32'h00);
        chk("t2_turn_grant", 32'({grant, busy}), 32'b0000_1);
        tick(); chk("t2_grant", 32'(grant), 32'b0010);
        chk("t2_oe", 32'(uio_oe), 32'hFF);
        for (int b = 0; b < 3; b++) begin
            tick(); chk("t2_beat_out", 32'(uio_out), 32'hA5);
            chk("t2_beat_grant", 32'(grant), 32'b0010);
        end
        tick(); chk("t2_last_grant", 32'({grant, busy}), 32'h0);
        chk("t2_last_out", 32'({uio_oe, uio_out}), 32'hFFA5);
        req = '0;
        tick(); chk("t2_park_oe", 32'(uio_oe), 32'hFF);

        // Read burst from requester 0 (ptr=2 wraps to 0), two beats then release
        req = 4'b0001; wr = 4'b0000; uio_in = 8'h3C;
        tick(); chk("t3_turn_oe", 32'({uio_oe, busy}), 32'h001);
        chk("t3_turn_grant", 32'(grant), 32'h0);
        tick(); chk("t3_grant", 32'(grant), 32'b0001);
        chk("t3_rvalid0", 32'(rvalid), 32'h0);
        tick(); chk("t3_beat1", 32'({rvalid, rdata}), 32'h13C);
        chk("t3_oe", 32'(uio_oe), 32'h00);
        uio_in = 8'h5A;
        tick(); chk("t3_beat2", 32'({rvalid, rdata}), 32'h15A);
        req = '0;
        tick(); chk("t3_end", 32'({grant, rvalid, busy}), 32'h0);
        chk("t3_park_oe", 32'(uio_oe), 32'h00);

        // Round robin from ptr=0: restart via reset between edges
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        req = 4'b1111; wr = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            uio_in = 8'(16 + k);
            tick(); chk("t4_grant", 32'(grant), 32'(oh));
            tick(); chk("t4_rd", 32'({rvalid, rdata}), 32'h100 + 32'(16 + k));
            req = req & ~oh;
            if (k == 3) req = req | 4'b0001;
            tick(); chk("t4_gap", 32'({grant, busy}), 32'h0);
        end

        // ena abort mid write burst, then re-grant pays a turnaround (ptr=1 -> req 2)
        req = 4'b0100; wr = 4'b0100; wdata = 32'h0077_0000;
        tick(); chk("t5_turn", 32'({grant, uio_oe}), 32'h000);
        tick(); chk("t5_grant", 32'({grant, uio_oe}), 32'h4FF);
        tick(); chk("t5_beat", 32'(uio_out), 32'h77);
        ena = 1'b0;
        tick(); chk("t5_abort", 32'({grant, uio_oe, busy, rvalid}), 32'h0);
        ena = 1'b1;
        tick(); chk("t5_return_oe", 32'({grant, uio_oe}), 32'h000);
        chk("t5_return_busy", 32'(busy), 32'h1);
        tick(); chk("t5_regrant", 32'({grant, uio_oe}), 32'h4FF);
        req = '0;
        tick(); chk("t5_zero_beat", 32'({grant, busy, uio_oe}), 32'h0FF);

        // Async reset mid read burst (ptr=3 -> req 3)
        req = 4'b1000; wr = 4'b0000; uio_in = 8'hC3;
        tick(); chk("t6_turn_oe", 32'(uio_oe), 32'h00);
        tick(); chk("t6_grant", 32'(grant), 32'b1000);
        tick(); chk("t6_beat", 32'({rvalid, rdata}), 32'h1C3);
        #1 rst_n = 1'b0;
        #1 chk("t6_async", 32'({grant, rvalid, busy, uio_oe, rdata}), 32'h0);
        #1 rst_n = 1'b1;
        req = 4'b1010;
        tick(); chk("t6_restart", 32'(grant), 32'b0010);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
